// File: rtl/contador_programa_pkg.sv
// Shared encodings for the program counter / fetch sequencer: pcControle codes,
// sequencer states and the opcodes that involve it.
package contador_programa_pkg;

  localparam logic [2:0] PC_INC  = 3'b000;
  localparam logic [2:0] PC_J    = 3'b001;
  localparam logic [2:0] PC_BR   = 3'b010;
  localparam logic [2:0] PC_JR   = 3'b011;
  localparam logic [2:0] PC_HOLD = 3'b111;

  localparam logic [5:0] OP_HLT = 6'd18;
  localparam logic [5:0] OP_IN  = 6'd19;

  typedef enum logic [2:0] {
    EXEC      = 3'd0,
    ESPERA_IN = 3'd1,
    CAPTURA   = 3'd2,
    GRAVA     = 3'd3,
    PARADO    = 3'd4
  } estado_t;

  // Codes 100/101/110 carry no meaning and fall back to a plain increment.
  function automatic logic codigo_reservado(input logic [2:0] codigo);
    return (codigo == 3'b100) || (codigo == 3'b101) || (codigo == 3'b110);
  endfunction

endpackage

// File: rtl/contador_programa_filtro_botao.sv
// Confirm-button conditioning: 2-flop synchroniser, optional debounce filter
// (enabled by defining DEBOUNCE_EN) and a rising-edge one-cycle pulse.
module filtro_botao #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic botao_i,
  output logic confirma_o
);

  logic sync1_q;
  logic sync2_q;
  logic nivel_s;
  logic anterior_q;

  // Two-stage synchroniser for the asynchronous push-button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= botao_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filtrado_q;
  logic             filtrado_d;

  // The filtered level only follows after DEB_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d      = cnt_q;
    filtrado_d = filtrado_q;
    if (sync2_q != filtrado_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        filtrado_d = sync2_q;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce counter and filtered level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      filtrado_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      filtrado_q <= filtrado_d;
    end
  end

  assign nivel_s = filtrado_q;
`else
  logic unused_deb_s;
  assign unused_deb_s = (DEB_CYCLES == 0);
  assign nivel_s      = sync2_q;
`endif

  // Previous conditioned level, used for the rising-edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      anterior_q <= 1'b0;
    end else begin
      anterior_q <= nivel_s;
    end
  end

  assign confirma_o = nivel_s & ~anterior_q;

endmodule

// File: rtl/contador_programa.sv
// Program counter and fetch sequencer: PC update, IN confirm handshake and HALT.
// Define DEBOUNCE_EN to filter the confirm button over DEB_CYCLES stable cycles.
module contador_programa
  import contador_programa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int OFFSET_W   = 10,
  parameter int RESET_PC   = 0,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          pcControle,
  input  logic                estagioEntradaUC,
  input  logic [ADDR_W-1:0]   enderecoSalto,
  input  logic [OFFSET_W-1:0] offsetDesvio,
  input  logic [31:0]         enderecoRegistrador,
  input  logic                botaoConfirma,
  output logic [ADDR_W-1:0]   pc,
  output logic                estagioEntradaSwitch,
  output logic                estagioEntradaBanco,
  output logic                parado
);

  localparam int EXT_W = (ADDR_W > OFFSET_W) ? ADDR_W : OFFSET_W;

  estado_t             estado_q;
  estado_t             estado_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic                switch_q;
  logic                switch_d;
  logic                banco_q;
  logic                banco_d;
  logic                parado_q;
  logic                parado_d;
  logic                confirma_s;
  logic [2:0]          codigo_s;
  logic [ADDR_W-1:0]   pc_inc_s;
  logic [EXT_W-1:0]    desvio_s;
  logic                unused_s;

  filtro_botao #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_filtro_botao (
    .clk_i      (clock),
    .rst_ni     (reset),
    .botao_i    (botaoConfirma),
    .confirma_o (confirma_s)
  );

  assign codigo_s = codigo_reservado(pcControle) ? PC_INC : pcControle;
  assign pc_inc_s = pc_q + ADDR_W'(1'b1);
  // Branch target is pc+1+offset, computed wide enough for either operand and truncated.
  assign desvio_s = EXT_W'(pc_q) + EXT_W'(1'b1) + EXT_W'($signed(offsetDesvio));
  assign unused_s = ^enderecoRegistrador;

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= EXEC;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      EXEC: begin
        if (codigo_s == PC_HOLD) begin
          estado_d = estagioEntradaUC ? ESPERA_IN : PARADO;
        end else begin
          estado_d = EXEC;
        end
      end
      ESPERA_IN: begin
        if (confirma_s) begin
          estado_d = CAPTURA;
        end else begin
          estado_d = ESPERA_IN;
        end
      end
      CAPTURA: estado_d = GRAVA;
      GRAVA:   estado_d = EXEC;
      PARADO:  estado_d = PARADO;
      default: estado_d = EXEC;
    endcase
  end

  // PC next value and flags, derived from the state being entered so they register cleanly.
  always_comb begin
    pc_d     = pc_q;
    switch_d = (estado_d == CAPTURA) || (estado_d == GRAVA);
    banco_d  = (estado_d == GRAVA);
    parado_d = (estado_d == PARADO);
    case (estado_q)
      EXEC: begin
        case (codigo_s)
          PC_INC:  pc_d = pc_inc_s;
          PC_J:    pc_d = enderecoSalto;
          PC_BR:   pc_d = desvio_s[ADDR_W-1:0];
          PC_JR:   pc_d = enderecoRegistrador[ADDR_W-1:0];
          PC_HOLD: pc_d = pc_q;
          default: pc_d = pc_inc_s;
        endcase
      end
      GRAVA:   pc_d = pc_inc_s;
      default: pc_d = pc_q;
    endcase
  end

  // PC and registered control-unit flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= ADDR_W'(RESET_PC);
      switch_q <= 1'b0;
      banco_q  <= 1'b0;
      parado_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      switch_q <= switch_d;
      banco_q  <= banco_d;
      parado_q <= parado_d;
    end
  end

  assign pc                   = pc_q;
  assign estagioEntradaSwitch = switch_q;
  assign estagioEntradaBanco  = banco_q;
  assign parado               = parado_q;

endmodule

// File: tb/tb_contador_programa.sv
// Randomised self-checking bench for contador_programa against an arithmetic PC model.
module tb_contador_programa;

  localparam int ADDR_W   = 10;
  localparam int OFFSET_W = 10;
  localparam int DEB      = 8;
  localparam int PC_MOD   = 1024;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [2:0]          pcControle = 3'b000;
  logic                estagioEntradaUC = 1'b0;
  logic [ADDR_W-1:0]   enderecoSalto = '0;
  logic [OFFSET_W-1:0] offsetDesvio = '0;
  logic [31:0]         enderecoRegistrador = 32'd0;
  logic                botaoConfirma = 1'b0;
  logic [ADDR_W-1:0]   pc;
  logic                sw;
  logic                banco;
  logic                parado;

  int errors = 0;
  int checks = 0;
  int exp_pc = 0;
  int gap    = 0;

  contador_programa #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .RESET_PC(0), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .pcControle(pcControle),
    .estagioEntradaUC(estagioEntradaUC), .enderecoSalto(enderecoSalto),
    .offsetDesvio(offsetDesvio), .enderecoRegistrador(enderecoRegistrador),
    .botaoConfirma(botaoConfirma), .pc(pc), .estagioEntradaSwitch(sw),
    .estagioEntradaBanco(banco), .parado(parado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int epc, input logic esw,
                           input logic ebk, input logic epar);
    check({tag, ".pc"}, 32'(pc), 32'(epc));
    check({tag, ".switch"}, 32'(sw), 32'(esw));
    check({tag, ".banco"}, 32'(banco), 32'(ebk));
    check({tag, ".parado"}, 32'(parado), 32'(epar));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference next-PC from the instruction-level rules, plain integer arithmetic.
  function automatic int ref_pc(input int cur, input int code, input int salto,
                                input int off, input logic [31:0] r);
    case (code)
      1:       return salto;
      2:       return (((cur + 1 + off) % PC_MOD) + PC_MOD) % PC_MOD;
      3:       return int'(r % 32'd1024);
      default: return (cur + 1) % PC_MOD;
    endcase
  endfunction

  task automatic exec_op(input int code, input int salto, input int off, input logic [31:0] r);
    pcControle          = 3'(code);
    estagioEntradaUC    = 1'b0;
    enderecoSalto       = 10'(salto);
    offsetDesvio        = 10'(off);
    enderecoRegistrador = r;
    tick();
    exp_pc = ref_pc(exp_pc, code, salto, off, r);
    check_all("exec", exp_pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    botaoConfirma = 1'b0;
    reset = 1'b0;
    #1;
    exp_pc = 0;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
  endtask

  // IN handshake; stale=1 means the button is already held on entry, glitch=1 adds a short press first.
  task automatic handshake(input int espera, input bit stale, input bit glitch);
    pcControle       = 3'b111;
    estagioEntradaUC = 1'b1;
    tick();
    check_all("in_enter", exp_pc, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < espera; i++) begin
      tick();
      check_all("in_wait", exp_pc, 1'b0, 1'b0, 1'b0);
    end
    if (stale || glitch) begin
      if (glitch) begin
        botaoConfirma = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tick();
          check_all("in_glitch", exp_pc, 1'b0, 1'b0, 1'b0);
        end
      end
      botaoConfirma = 1'b0;
      for (int i = 0; i < LAT + 6; i++) begin
        tick();
        check_all("in_release", exp_pc, 1'b0, 1'b0, 1'b0);
      end
    end
    botaoConfirma = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check_all("in_latency", exp_pc, (i == LAT), 1'b0, 1'b0);
    end
    tick();
    check_all("in_grava", exp_pc, 1'b1, 1'b1, 1'b0);
    pcControle       = 3'b000;
    estagioEntradaUC = 1'b0;
    tick();
    exp_pc = (exp_pc + 1) % PC_MOD;
    check_all("in_exit", exp_pc, 1'b0, 1'b0, 1'b0);
    botaoConfirma = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_all("por", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) exec_op(0, 0, 0, 32'd0);
    exec_op(1, 5, 0, 32'd0);
    exec_op(2, 0, -3, 32'd0);
    exec_op(1, 1023, 0, 32'd0);
    exec_op(0, 0, 0, 32'd0);
    exec_op(1, 200, 0, 32'd0);
    exec_op(3, 0, 0, 32'h0000_0412);
    exec_op(4, 0, 0, 32'd0);
    exec_op(6, 0, 0, 32'd0);

    // Press while still executing: that edge must not satisfy the coming IN.
    botaoConfirma = 1'b1;
    for (int i = 0; i < LAT + 2; i++) exec_op(1, 7, 0, 32'd0);
    handshake(20, 1'b1, 1'b0);
    for (int i = 0; i < LAT + 4; i++) exec_op(0, 0, 0, 32'd0);

`ifdef DEBOUNCE_EN
    handshake(2, 1'b0, 1'b1);
    for (int i = 0; i < LAT + 4; i++) exec_op(0, 0, 0, 32'd0);
`endif

    // Reset while in CAPTURA.
    pcControle       = 3'b111;
    estagioEntradaUC = 1'b1;
    tick();
    botaoConfirma = 1'b1;
    repeat (LAT) tick();
    check("captura_reached", 32'(sw), 32'd1);
    do_reset();
    pcControle       = 3'b000;
    estagioEntradaUC = 1'b0;
    for (int i = 0; i < LAT + 4; i++) exec_op(0, 0, 0, 32'd0);

    gap = 0;
    for (int n = 0; n < 400; n++) begin
      if (gap >= LAT + 6 && $urandom_range(0, 99) < 6) begin
        handshake(int'($urandom_range(0, 12)), 1'b0, 1'b0);
        gap = 0;
      end else begin
        exec_op(int'($urandom_range(0, 6)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)) - 512, $urandom());
        gap++;
      end
    end

    // Halt at pc=9: everything frozen until reset.
    exec_op(1, 9, 0, 32'd0);
    pcControle       = 3'b111;
    estagioEntradaUC = 1'b0;
    tick();
    check_all("halt", 9, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      pcControle       = 3'($urandom_range(0, 7));
      estagioEntradaUC = 1'($urandom_range(0, 1));
      botaoConfirma    = 1'($urandom_range(0, 1));
      enderecoSalto    = 10'($urandom_range(0, 1023));
      tick();
      check_all("halted", 9, 1'b0, 1'b0, 1'b1);
    end
    do_reset();
    pcControle = 3'b000;
    exec_op(0, 0, 0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
